// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory with one-cycle read latency.
// Define ARB_STARVE_GUARD_EN to build the port B starvation guard.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 20,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_value,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_value
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_A = 2'd1;
    localparam logic [1:0] OWN_B = 2'd2;

    logic [1:0]            owner_q, owner_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  force_b;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    assign force_b = b_req && (starve_cnt_q == LIMIT);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!b_req || b_gnt)
            starve_cnt_d = '0;
        else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            starve_cnt_q <= '0;
        else
            starve_cnt_q <= starve_cnt_d;
    end
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT > 0);
    assign force_b = 1'b0;
`endif

    // Grants are forced low while reset is asserted, whatever the requests.
    assign a_gnt = !reset && a_req && !force_b;
    assign b_gnt = !reset && b_req && (!a_req || force_b);

    assign mem_addr         = a_gnt ? a_addr : (b_gnt ? b_addr : addr_q);
    assign mem_write_value  = b_gnt ? b_wdata : a_wdata;
    assign mem_write_enable = (a_gnt && a_we) || (b_gnt && b_we);

    always_comb begin
        owner_d = IDLE;
        if (a_gnt)
            owner_d = OWN_A;
        else if (b_gnt)
            owner_d = OWN_B;
        rd_d = (a_gnt && !a_we) || (b_gnt && !b_we);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= IDLE;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            owner_q <= owner_d;
            rd_q    <= rd_d;
            addr_q  <= mem_addr;
        end
    end

    // Returning data follows the previous owner, not the current grant.
    assign a_rvalid = rd_q && (owner_q == OWN_A);
    assign b_rvalid = rd_q && (owner_q == OWN_B);
    assign rdata    = (a_rvalid || b_rvalid) ? mem_read_value : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency memory.
// Starvation-guard checks are built only when ARB_STARVE_GUARD_EN is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, b_addr;
    logic [19:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [19:0] rdata;
    logic [15:0] mem_addr;
    logic [19:0] mem_write_value;
    logic        mem_write_enable;
    logic [19:0] mem_read_value;

    logic [19:0] mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (20),
        .STARVE_LIMIT(8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .a_req           (a_req),
        .a_we            (a_we),
        .a_addr          (a_addr),
        .a_wdata         (a_wdata),
        .a_gnt           (a_gnt),
        .a_rvalid        (a_rvalid),
        .b_req           (b_req),
        .b_we            (b_we),
        .b_addr          (b_addr),
        .b_wdata         (b_wdata),
        .b_gnt           (b_gnt),
        .b_rvalid        (b_rvalid),
        .rdata           (rdata),
        .mem_addr        (mem_addr),
        .mem_write_value (mem_write_value),
        .mem_write_enable(mem_write_enable),
        .mem_read_value  (mem_read_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_enable)
            mem[mem_addr] <= mem_write_value;
        mem_read_value <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic a_write(input logic [15:0] ad, input logic [19:0] d);
        a_req = 1; a_we = 1; a_addr = ad; a_wdata = d;
        tick();
        a_req = 0; a_we = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem_read_value = '0;
        idle_inputs();
        reset = 1;
        a_req = 1; b_req = 1;
        @(negedge clk);
        check("rst_a_gnt", 32'(a_gnt), 0);
        check("rst_b_gnt", 32'(b_gnt), 0);
        check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 0);
        check("rst_we", 32'(mem_write_enable), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_owner", 32'(dut.owner_q), 0);
        tick();
        reset = 0;
        idle_inputs();
        tick();

        // Write 0x12345 to 0x0010 then read it back.
        a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 20'h12345;
        @(negedge clk);
        check("w_a_gnt", 32'(a_gnt), 1);
        check("w_we", 32'(mem_write_enable), 1);
        check("w_addr", 32'(mem_addr), 32'h10);
        check("w_data", 32'(mem_write_value), 32'h12345);
        tick();
        a_we = 0;
        @(negedge clk);
        check("r_a_gnt", 32'(a_gnt), 1);
        check("r_no_rvalid", 32'(a_rvalid), 0);
        check("r_we", 32'(mem_write_enable), 0);
        tick();
        a_req = 0;
        @(negedge clk);
        check("r_a_rvalid", 32'(a_rvalid), 1);
        check("r_rdata", 32'(rdata), 32'h12345);
        check("hold_addr", 32'(mem_addr), 32'h10);
        check("idle_we", 32'(mem_write_enable), 0);
        tick();
        @(negedge clk);
        check("r_pulse_end", 32'(a_rvalid), 0);
        check("idle_owner", 32'(dut.owner_q), 0);

        a_write(16'd5, 20'h00055);
        a_write(16'd6, 20'h00066);

        // Simultaneous reads: A first, B next cycle.
        a_req = 1; a_addr = 16'd5;
        b_req = 1; b_addr = 16'd6;
        @(negedge clk);
        check("both_a_gnt", 32'(a_gnt), 1);
        check("both_b_gnt", 32'(b_gnt), 0);
        tick();
        a_req = 0;
        @(negedge clk);
        check("seq_b_gnt", 32'(b_gnt), 1);
        check("seq_a_rvalid", 32'(a_rvalid), 1);
        check("seq_b_rvalid0", 32'(b_rvalid), 0);
        check("seq_rdata5", 32'(rdata), 32'h55);
        check("seq_owner_a", 32'(dut.owner_q), 1);
        tick();
        b_req = 0;
        @(negedge clk);
        check("seq_b_rvalid", 32'(b_rvalid), 1);
        check("seq_a_rvalid0", 32'(a_rvalid), 0);
        check("seq_rdata6", 32'(rdata), 32'h66);
        tick();
        @(negedge clk);
        check("seq_done", 32'({a_rvalid, b_rvalid}), 0);

        // Reset in the cycle after a B read grant drops the read.
        b_req = 1; b_addr = 16'd6;
        @(negedge clk);
        check("rb_b_gnt", 32'(b_gnt), 1);
        tick();
        b_req = 0; reset = 1;
        @(negedge clk);
        check("rb_rvalid_rst", 32'(b_rvalid), 0);
        tick();
        reset = 0;
        @(negedge clk);
        check("rb_rvalid_post", 32'(b_rvalid), 0);
        check("rb_owner", 32'(dut.owner_q), 0);
`ifdef ARB_STARVE_GUARD_EN
        check("rb_starve", 32'(dut.starve_cnt_q), 0);
`endif
        tick();

        // B requests for 3 cycles behind A, then withdraws.
        a_req = 1; a_addr = 16'd5;
        b_req = 1; b_addr = 16'd6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wd_b_gnt", 32'(b_gnt), 0);
            check("wd_b_rvalid", 32'(b_rvalid), 0);
`ifdef ARB_STARVE_GUARD_EN
            check("wd_starve", 32'(dut.starve_cnt_q), 32'(i));
`endif
            tick();
        end
        b_req = 0;
        @(negedge clk);
        check("wd_b_gnt_drop", 32'(b_gnt), 0);
        tick();
        a_req = 0;
        @(negedge clk);
        check("wd_b_rvalid_end", 32'(b_rvalid), 0);
`ifdef ARB_STARVE_GUARD_EN
        check("wd_starve_clr", 32'(dut.starve_cnt_q), 0);
`endif
        tick();
        tick();

        // Continuous contention from both ports.
        a_req = 1; b_req = 1;
`ifdef ARB_STARVE_GUARD_EN
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            check("sg_b_gnt", 32'(b_gnt), 32'(i % 9 == 8));
            check("sg_a_gnt", 32'(a_gnt), 32'(i % 9 != 8));
            tick();
        end
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("strict_b_gnt", 32'(b_gnt), 0);
            tick();
        end
`endif
        idle_inputs();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, word address width of the shared memory.
REQ-002 Parameter DATA_WIDTH, default 20, memory word width (16-bit value plus tag bits).
REQ-003 Parameter STARVE_LIMIT, default 8, consecutive denied cycles before port B is force-granted.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 a_req / a_we  input  1 / 1  port A (core) access request and write enable.
REQ-007 a_addr / a_wdata  input  ADDR_WIDTH / DATA_WIDTH  port A address and write data.
REQ-008 a_gnt / a_rvalid  output  1 / 1  port A access issued this cycle / read data valid.
REQ-009 b_req / b_we / b_addr / b_wdata  input  1/1/ADDR_WIDTH/DATA_WIDTH  port B (background collector/loader), same meaning as port A.
REQ-010 b_gnt / b_rvalid  output  1 / 1  port B grant / read data valid.
REQ-011 rdata  output  DATA_WIDTH  read data, shared by both ports, qualified by a_rvalid or b_rvalid.
REQ-012 mem_addr / mem_write_value / mem_write_enable  output  ADDR_WIDTH / DATA_WIDTH / 1  single-port memory controls.
REQ-013 mem_read_value  input  DATA_WIDTH  memory read data, valid one cycle after the address is presented.

Function
REQ-014 Grant decision is combinational in the request cycle; at most one of a_gnt, b_gnt is high per cycle.
REQ-015 A request is issued only in a cycle where its gnt is high; mem_addr, mem_write_value and mem_write_enable then come from the granted port.
REQ-016 With no grant: mem_write_enable = 0, mem_addr holds its last issued value, mem_write_value is don't-care.
REQ-017 A requester holds req, we, addr and wdata stable until it sees gnt; deasserting req without a grant is legal and withdraws the request.
REQ-018 Default priority: a_req beats b_req when both are asserted.
REQ-019 Registered state owner in {IDLE, OWN_A, OWN_B} records the port granted in the previous cycle; IDLE when no grant was given.
REQ-020 A granted read (we = 0) raises that port's rvalid for exactly one cycle, one cycle after gnt, with rdata = mem_read_value.
REQ-021 A granted write raises no rvalid; memory is written at the grant edge.
REQ-022 Back-to-back grants to either port in consecutive cycles are permitted (full throughput, one access per cycle).
REQ-023 A read granted to A followed immediately by a grant to B routes the returning data to a_rvalid only; rvalid follows owner, not the current grant.
REQ-024 starve_cnt (width ceil(log2(STARVE_LIMIT+1))) increments each cycle b_req is high and b_gnt is low, saturates at STARVE_LIMIT, and clears on b_gnt or when b_req is low.

Reset
REQ-025 During and after reset: a_gnt = b_gnt = 0, a_rvalid = b_rvalid = 0, mem_write_enable = 0, mem_addr = 0, rdata = 0, owner = IDLE, starve_cnt = 0.
REQ-026 Reset asserted in the cycle after a read grant suppresses that read's rvalid; the access is lost and the requester re-issues it.
REQ-027 Grants are held low while reset is high, regardless of req inputs.

Configuration
REQ-028 Macro ARB_STARVE_GUARD_EN compiled in: when starve_cnt == STARVE_LIMIT and b_req is high, B wins for one cycle over a_req, and a_gnt stays low that cycle.
REQ-029 Macro absent: strict A priority; starve_cnt and its logic are not built; B is granted only when a_req is low.

Verification
REQ-030 After reset, with a_req = 1, a_we = 1, a_addr = 0x0010, a_wdata = 0x12345, then a read of 0x0010 -> a_gnt high both cycles; a_rvalid high one cycle later with rdata = 0x12345.
REQ-031 a_req and b_req both high for one cycle, both reads -> a_gnt = 1 and b_gnt = 0; the next cycle, with a_req low, b_gnt = 1; a_rvalid and b_rvalid each pulse once, in order.
REQ-032 With ARB_STARVE_GUARD_EN, STARVE_LIMIT = 8, a_req and b_req held high continuously -> b_gnt first high in cycle 9 with a_gnt low that cycle; the pattern repeats every 9 cycles. Without the macro, b_gnt stays 0 for 100 cycles.
REQ-033 A read of addr 5 granted to A, then a read of addr 6 granted to B in the next cycle -> a_rvalid with mem[5], then b_rvalid with mem[6] one cycle later; rvalids are never high together.
REQ-034 reset pulsed high in the cycle after a B read grant -> b_rvalid stays 0, starve_cnt = 0, and owner = IDLE after reset is released.
REQ-035 b_req raised for 3 cycles while a_req is high, then dropped before any grant -> no b_gnt is issued, no b_rvalid is issued, and starve_cnt returns to 0.
